updn_counter_gen: RTL and testbench

UPDN_COUNTER_GEN -- requirements
Module: updn_counter_gen

---
 rtl/updn_counter_gen.sv | 100 ++++++++++
 tb/tb_updn_counter_gen.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/updn_counter_gen.sv
// Parameterised up/down counter with variable step, wrap or saturate at 0..MAX_VAL,
// registered terminal-count pulses and sticky overflow/underflow flags.
module updn_counter_gen #(
    parameter int          WIDTH    = 8,
    parameter logic [31:0] MAX_VAL  = 32'((64'd1 << WIDTH) - 64'd1),
    parameter int          STEP_W   = 4,
    parameter bit          SAT_MODE = 1'b0
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              ld_cnt_,
    input  logic              updn_cnt,
    input  logic              count_enb,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              clr_flags,
    output logic [WIDTH-1:0]  data_out,
    output logic              tc_up,
    output logic              tc_dn,
    output logic              ovf_sticky,
    output logic              unf_sticky
);

    // One extra bit so sums and wrap corrections never truncate.
    localparam int             XW    = WIDTH + 1;
    localparam logic [WIDTH-1:0] MAX_W = MAX_VAL[WIDTH-1:0];
    localparam logic [XW-1:0]  LIM   = {1'b0, MAX_W};
    localparam logic [XW-1:0]  MOD   = LIM + XW'(1);

    logic [XW-1:0]    cur_x;
    logic [XW-1:0]    step_x;
    logic [XW-1:0]    step_m;
    logic [XW-1:0]    sum_x;
    logic [XW-1:0]    up_wrap;
    logic [XW-1:0]    dn_wrap;
    logic [WIDTH-1:0] cnt_nxt;
    logic             tc_up_nxt;
    logic             tc_dn_nxt;

    assign cur_x  = {1'b0, data_out};
    assign step_x = XW'(step);
    // Steps larger than the range are folded back into it before wrapping.
    assign step_m = step_x % MOD;
    assign sum_x  = cur_x + step_x;

    always_comb begin
        up_wrap = cur_x + step_m;
        if (up_wrap > LIM) begin
            up_wrap = up_wrap - MOD;
        end
        if (step_m > cur_x) begin
            dn_wrap = cur_x + MOD - step_m;
        end else begin
            dn_wrap = cur_x - step_m;
        end
    end

    always_comb begin
        cnt_nxt   = data_out;
        tc_up_nxt = 1'b0;
        tc_dn_nxt = 1'b0;
        if (!ld_cnt_) begin
            cnt_nxt = (data_in > MAX_W) ? MAX_W : data_in;
        end else if (count_enb && (step != '0)) begin
            if (updn_cnt) begin
                if (sum_x > LIM) begin
                    tc_up_nxt = 1'b1;
                    cnt_nxt   = SAT_MODE ? MAX_W : WIDTH'(up_wrap);
                end else begin
                    cnt_nxt = WIDTH'(sum_x);
                end
            end else begin
                if (step_x > cur_x) begin
                    tc_dn_nxt = 1'b1;
                    cnt_nxt   = SAT_MODE ? '0 : WIDTH'(dn_wrap);
                end else begin
                    cnt_nxt = WIDTH'(cur_x - step_x);
                end
            end
        end
    end

    // A terminal-count event in the same cycle as clr_flags keeps the flag set.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            data_out   <= '0;
            tc_up      <= 1'b0;
            tc_dn      <= 1'b0;
            ovf_sticky <= 1'b0;
            unf_sticky <= 1'b0;
        end else begin
            data_out   <= cnt_nxt;
            tc_up      <= tc_up_nxt;
            tc_dn      <= tc_dn_nxt;
            ovf_sticky <= tc_up_nxt | (ovf_sticky & ~clr_flags);
            unf_sticky <= tc_dn_nxt | (unf_sticky & ~clr_flags);
        end
    end

endmodule

// File: tb/tb_updn_counter_gen.sv
// Bench for updn_counter_gen: three instances (wrap MAX 9, saturate MAX 255, defaults)
// share one set of inputs; directed scenarios plus a randomized run against a model.
module tb_updn_counter_gen;

    logic       clk = 1'b0;
    logic       rst_;
    logic       ld_cnt_;
    logic       updn_cnt;
    logic       count_enb;
    logic [3:0] step;
    logic [7:0] data_in;
    logic       clr_flags;

    // index 0: WIDTH 8, MAX 9, wrap; 1: MAX 255, saturate; 2: all defaults
    logic [7:0] q_a[3];
    logic       tu_a[3];
    logic       td_a[3];
    logic       ovf_a[3];
    logic       unf_a[3];

    int checks = 0;
    int errors = 0;

    longint maxv_t[3] = '{9, 255, 255};
    bit     sat_t[3]  = '{1'b0, 1'b1, 1'b0};

    always #5 clk = ~clk;

    updn_counter_gen #(.WIDTH(8), .MAX_VAL(32'd9), .STEP_W(4), .SAT_MODE(1'b0)) u_wrap9 (
        .clk(clk), .rst_(rst_), .ld_cnt_(ld_cnt_), .updn_cnt(updn_cnt),
        .count_enb(count_enb), .step(step), .data_in(data_in), .clr_flags(clr_flags),
        .data_out(q_a[0]), .tc_up(tu_a[0]), .tc_dn(td_a[0]),
        .ovf_sticky(ovf_a[0]), .unf_sticky(unf_a[0]));

    updn_counter_gen #(.WIDTH(8), .MAX_VAL(32'd255), .STEP_W(4), .SAT_MODE(1'b1)) u_sat (
        .clk(clk), .rst_(rst_), .ld_cnt_(ld_cnt_), .updn_cnt(updn_cnt),
        .count_enb(count_enb), .step(step), .data_in(data_in), .clr_flags(clr_flags),
        .data_out(q_a[1]), .tc_up(tu_a[1]), .tc_dn(td_a[1]),
        .ovf_sticky(ovf_a[1]), .unf_sticky(unf_a[1]));

    updn_counter_gen u_def (
        .clk(clk), .rst_(rst_), .ld_cnt_(ld_cnt_), .updn_cnt(updn_cnt),
        .count_enb(count_enb), .step(step), .data_in(data_in), .clr_flags(clr_flags),
        .data_out(q_a[2]), .tc_up(tu_a[2]), .tc_dn(td_a[2]),
        .ovf_sticky(ovf_a[2]), .unf_sticky(unf_a[2]));

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_in(input bit ld, input bit up, input bit en, input int st,
                          input int din, input bit clr);
        ld_cnt_   = ld;
        updn_cnt  = up;
        count_enb = en;
        step      = 4'(st);
        data_in   = 8'(din);
        clr_flags = clr;
    endtask

    task automatic test_reset();
        rst_ = 1'b0;
        for (int c = 0; c < 3; c++) begin
            set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1,
                   int'($urandom_range(1, 15)), int'($urandom_range(0, 255)), 1'b0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (q_a[i] !== 8'd0 || tu_a[i] !== 1'b0 || td_a[i] !== 1'b0 ||
                ovf_a[i] !== 1'b0 || unf_a[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset inst%0d: q=%0d tu=%b td=%b ovf=%b unf=%b, required all 0",
                         i, q_a[i], tu_a[i], td_a[i], ovf_a[i], unf_a[i]);
            end
        end
        rst_ = 1'b1;
    endtask

    task automatic test_wrap_limit();
        set_in(0, 1, 1, 2, 7, 1);
        tick();
        checks++;
        if (q_a[0] !== 8'd7 || ovf_a[0] !== 1'b0) begin
            errors++; $display("FAIL wrap_load: q=%0d ovf=%b, required 7/0", q_a[0], ovf_a[0]);
        end
        set_in(1, 1, 1, 2, 0, 0);
        tick();
        checks++;
        if (q_a[0] !== 8'd9 || tu_a[0] !== 1'b0) begin
            errors++; $display("FAIL wrap_hit9: q=%0d tu=%b, required 9/0", q_a[0], tu_a[0]);
        end
        tick();
        checks++;
        if (q_a[0] !== 8'd1 || tu_a[0] !== 1'b1 || ovf_a[0] !== 1'b1) begin
            errors++;
            $display("FAIL wrap_cross: q=%0d tu=%b ovf=%b, required 1/1/1", q_a[0], tu_a[0], ovf_a[0]);
        end
        set_in(1, 1, 0, 2, 0, 0);
        tick();
        checks++;
        if (q_a[0] !== 8'd1 || tu_a[0] !== 1'b0 || ovf_a[0] !== 1'b1) begin
            errors++;
            $display("FAIL wrap_pulse_end: q=%0d tu=%b ovf=%b, required 1/0/1", q_a[0], tu_a[0], ovf_a[0]);
        end
    endtask

    task automatic test_sat_floor();
        set_in(0, 0, 1, 5, 3, 1);
        tick();
        checks++;
        if (q_a[1] !== 8'd3 || unf_a[1] !== 1'b0) begin
            errors++; $display("FAIL sat_load: q=%0d unf=%b, required 3/0", q_a[1], unf_a[1]);
        end
        set_in(1, 0, 1, 5, 0, 0);
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (q_a[1] !== 8'd0 || td_a[1] !== 1'b1 || unf_a[1] !== 1'b1) begin
                errors++;
                $display("FAIL sat_floor%0d: q=%0d td=%b unf=%b, required 0/1/1", c, q_a[1], td_a[1], unf_a[1]);
            end
        end
        set_in(0, 1, 1, 1, 255, 0);
        tick();
        set_in(1, 1, 1, 1, 0, 0);
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (q_a[1] !== 8'd255 || tu_a[1] !== 1'b1 || td_a[1] !== 1'b0) begin
                errors++;
                $display("FAIL sat_ceiling%0d: q=%0d tu=%b td=%b, required 255/1/0", c, q_a[1], tu_a[1], td_a[1]);
            end
        end
    endtask

    task automatic test_load_hold();
        set_in(0, 1, 1, 3, 8'hA5, 0);
        tick();
        checks++;
        if (q_a[2] !== 8'hA5 || tu_a[2] !== 1'b0 || td_a[2] !== 1'b0) begin
            errors++;
            $display("FAIL load_prio: q=%h tu=%b td=%b, required a5/0/0", q_a[2], tu_a[2], td_a[2]);
        end
        set_in(1, 1, 0, 3, 0, 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (q_a[2] !== 8'hA5) begin
                errors++; $display("FAIL hold_disabled%0d: q=%h, required a5", c, q_a[2]);
            end
        end
        set_in(1, 0, 1, 0, 0, 0);
        tick();
        checks++;
        if (q_a[2] !== 8'hA5 || td_a[2] !== 1'b0) begin
            errors++; $display("FAIL hold_step0: q=%h td=%b, required a5/0", q_a[2], td_a[2]);
        end
    endtask

    task automatic test_clamp();
        set_in(0, 1, 1, 1, 200, 0);
        tick();
        checks++;
        if (q_a[0] !== 8'd9) begin
            errors++; $display("FAIL clamp_max9: q=%0d, required 9", q_a[0]);
        end
        checks++;
        if (q_a[2] !== 8'd200) begin
            errors++; $display("FAIL load_noclamp: q=%0d, required 200", q_a[2]);
        end
    endtask

    task automatic test_clr_flags();
        set_in(0, 1, 1, 1, 9, 1);
        tick();
        checks++;
        if (q_a[0] !== 8'd9 || ovf_a[0] !== 1'b0) begin
            errors++; $display("FAIL clr_idle: q=%0d ovf=%b, required 9/0", q_a[0], ovf_a[0]);
        end
        set_in(1, 1, 1, 1, 0, 0);
        tick();
        checks++;
        if (q_a[0] !== 8'd0 || tu_a[0] !== 1'b1 || ovf_a[0] !== 1'b1) begin
            errors++;
            $display("FAIL clr_setup: q=%0d tu=%b ovf=%b, required 0/1/1", q_a[0], tu_a[0], ovf_a[0]);
        end
        set_in(1, 1, 1, 15, 0, 1);
        tick();
        checks++;
        if (q_a[0] !== 8'd5 || tu_a[0] !== 1'b1 || ovf_a[0] !== 1'b1) begin
            errors++;
            $display("FAIL clr_vs_set: q=%0d tu=%b ovf=%b, required 5/1/1", q_a[0], tu_a[0], ovf_a[0]);
        end
        set_in(1, 1, 0, 15, 0, 1);
        tick();
        checks++;
        if (ovf_a[0] !== 1'b0 || tu_a[0] !== 1'b0) begin
            errors++; $display("FAIL clr_apply: ovf=%b tu=%b, required 0/0", ovf_a[0], tu_a[0]);
        end
    endtask

    task automatic test_async_reset();
        set_in(0, 1, 1, 1, 8'h40, 0);
        tick();
        set_in(1, 1, 1, 1, 0, 0);
        tick();
        tick();
        checks++;
        if (q_a[2] !== 8'h42) begin
            errors++; $display("FAIL pre_reset_count: q=%h, required 42", q_a[2]);
        end
        #2 rst_ = 1'b0;
        #1;
        checks++;
        if (q_a[2] !== 8'd0 || tu_a[2] !== 1'b0 || td_a[2] !== 1'b0 ||
            ovf_a[2] !== 1'b0 || unf_a[2] !== 1'b0 || q_a[0] !== 8'd0) begin
            errors++;
            $display("FAIL async_reset: q=%h tu=%b td=%b ovf=%b unf=%b q0=%0d, required all 0",
                     q_a[2], tu_a[2], td_a[2], ovf_a[2], unf_a[2], q_a[0]);
        end
        #1 rst_ = 1'b1;
        tick();
        checks++;
        if (q_a[2] !== 8'd1) begin
            errors++; $display("FAIL post_reset_count: q=%0d, required 1", q_a[2]);
        end
    endtask

    task automatic test_random();
        longint mq[3];
        bit     mo[3];
        bit     mu[3];
        bit     mtu[3];
        bit     mtd[3];
        longint s;
        longint m;
        rst_ = 1'b0;
        tick();
        rst_ = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mq[i] = 0; mo[i] = 0; mu[i] = 0;
        end
        for (int c = 0; c < 600; c++) begin
            set_in($urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3) != 0, int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 255)), $urandom_range(0, 7) == 0);
            for (int i = 0; i < 3; i++) begin
                m = maxv_t[i] + 1;
                mtu[i] = 0;
                mtd[i] = 0;
                if (!ld_cnt_) begin
                    mq[i] = (longint'(data_in) > maxv_t[i]) ? maxv_t[i] : longint'(data_in);
                end else if (count_enb && step != 0) begin
                    s = updn_cnt ? mq[i] + longint'(step) : mq[i] - longint'(step);
                    if (s > maxv_t[i]) begin
                        mtu[i] = 1;
                        mq[i] = sat_t[i] ? maxv_t[i] : s % m;
                    end else if (s < 0) begin
                        mtd[i] = 1;
                        mq[i] = sat_t[i] ? 0 : ((s % m) + m) % m;
                    end else begin
                        mq[i] = s;
                    end
                end
                mo[i] = mtu[i] || (mo[i] && !clr_flags);
                mu[i] = mtd[i] || (mu[i] && !clr_flags);
            end
            tick();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (q_a[i] !== 8'(mq[i]) || tu_a[i] !== mtu[i] || td_a[i] !== mtd[i] ||
                    ovf_a[i] !== mo[i] || unf_a[i] !== mu[i]) begin
                    errors++;
                    $display("FAIL random c%0d inst%0d: q=%0d tu=%b td=%b ovf=%b unf=%b, required %0d/%b/%b/%b/%b",
                             c, i, q_a[i], tu_a[i], td_a[i], ovf_a[i], unf_a[i],
                             mq[i], mtu[i], mtd[i], mo[i], mu[i]);
                end
                checks++;
                if ((tu_a[i] && td_a[i]) || longint'(q_a[i]) > maxv_t[i]) begin
                    errors++;
                    $display("FAIL invariant c%0d inst%0d: q=%0d tu=%b td=%b, required q<=%0d and not both tc",
                             c, i, q_a[i], tu_a[i], td_a[i], maxv_t[i]);
                end
            end
        end
    endtask

    initial begin
        rst_ = 1'b0;
        set_in(1, 1, 0, 0, 0, 0);
        test_reset();
        test_wrap_limit();
        test_sat_floor();
        test_load_hold();
        test_clamp();
        test_clr_flags();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
